// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer that drives an external 4-bit ALU slice to compute a 4*NIBBLES-bit result.
// Optional signed-overflow flag is enabled with macro ALU_NIBBLE_SEQ_OVF_EN.
module alu_nibble_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic [3:0]             op_s,
   input  logic                   op_m,
   input  logic                   op_cin,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic [3:0]             alu_s,
   output logic                   alu_m,
   output logic                   alu_cin_re,
   input  logic [3:0]             alu_y,
   input  logic                   alu_cout_re,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
`ifdef ALU_NIBBLE_SEQ_OVF_EN
   output logic                   ovf,
`endif
   output logic                   zero
);

   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [KW-1:0]   r_k;
   logic [KW+1:0]   w_base;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [3:0]      r_s;
   logic            r_m;
   logic            r_cin;
   logic            r_chain_re;
   logic [W-1:0]    r_result;
   logic [W-1:0]    w_result_nxt;
   logic            r_cout;
   logic            r_zero;
   logic            w_accept;
   logic            w_last;

   assign w_base = {r_k, 2'b00};

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      alu_a       = 4'h0;
      alu_b       = 4'h0;
      alu_s       = 4'h0;
      alu_m       = 1'b0;
      alu_cin_re  = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy  = 1'b1;
            alu_a = r_a[w_base +: 4];
            alu_b = r_b[w_base +: 4];
            alu_s = r_s;
            alu_m = r_m;
            // Logic mode keeps the carry inactive; nibble 0 takes the external carry.
            if (!r_m) alu_cin_re = (r_k == '0) ? ~r_cin : r_chain_re;
            if (r_k == KW'(NIBBLES - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_result_nxt = r_result;
      w_result_nxt[w_base +: 4] = alu_y;
   end

   always_ff @(posedge clk) begin
      if (w_accept && !rst) begin
         r_a   <= op_a;
         r_b   <= op_b;
         r_s   <= op_s;
         r_m   <= op_m;
         r_cin <= op_cin;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k        <= '0;
         r_result   <= '0;
         r_cout     <= 1'b0;
         r_zero     <= 1'b0;
         r_chain_re <= 1'b1;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
         ovf        <= 1'b0;
`endif
      end else if (w_accept) begin
         r_k <= '0;
      end else if (r_state == S_RUN) begin
         r_result   <= w_result_nxt;
         r_chain_re <= alu_cout_re;
         r_k        <= r_k + KW'(1);
         if (w_last) begin
            r_cout <= ~r_m & ~alu_cout_re;
            r_zero <= (w_result_nxt == '0);
`ifdef ALU_NIBBLE_SEQ_OVF_EN
            // Signed overflow only for add (s=9) and subtract (s=6) in arithmetic mode.
            if (!r_m && r_s == 4'h9)
               ovf <= (r_a[W-1] == r_b[W-1]) & (w_result_nxt[W-1] != r_a[W-1]);
            else if (!r_m && r_s == 4'h6)
               ovf <= (r_a[W-1] != r_b[W-1]) & (w_result_nxt[W-1] != r_a[W-1]);
            else
               ovf <= 1'b0;
`endif
         end
      end
   end

   assign result = r_result;
   assign cout   = r_cout;
   assign zero   = r_zero;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq with a behavioural 4-bit ALU slice attached.
// Build with ALU_NIBBLE_SEQ_OVF_EN to also exercise the overflow flag.
module tb_alu_nibble_seq;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [W-1:0]  op_a, op_b;
   logic [3:0]    op_s;
   logic          op_m, op_cin;
   logic [3:0]    alu_a, alu_b, alu_s, alu_y;
   logic          alu_m, alu_cin_re, alu_cout_re;
   logic          busy, done, cout, zero;
   logic [W-1:0]  result;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
   logic          ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int lat, npulse;
   logic cin_ok;

   always #5 clk = ~clk;

   alu_nibble_seq #(.NIBBLES(NIB)) dut (
      .clk(clk), .rst(rst), .start(start),
      .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
      .alu_cin_re(alu_cin_re), .alu_y(alu_y), .alu_cout_re(alu_cout_re),
      .busy(busy), .done(done), .result(result), .cout(cout),
`ifdef ALU_NIBBLE_SEQ_OVF_EN
      .ovf(ovf),
`endif
      .zero(zero)
   );

   // 4-bit ALU slice: subset of a 181-style function table, active-low carries.
   logic [4:0] w_t;
   logic       w_c;
   always_comb begin
      w_t         = 5'd0;
      w_c         = ~alu_cin_re;
      alu_y       = 4'h0;
      alu_cout_re = 1'b1;
      if (alu_m) begin
         case (alu_s)
            4'h0:    alu_y = ~alu_a;
            4'h6:    alu_y = alu_a ^ alu_b;
            4'h9:    alu_y = ~(alu_a ^ alu_b);
            4'hB:    alu_y = alu_a & alu_b;
            4'hE:    alu_y = alu_a | alu_b;
            default: alu_y = alu_a;
         endcase
      end else begin
         case (alu_s)
            4'h9:    w_t = {1'b0, alu_a} + {1'b0, alu_b}  + {4'd0, w_c};
            4'h6:    w_t = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, w_c};
            4'hF:    w_t = {1'b0, alu_a} + 5'h0F          + {4'd0, w_c};
            default: w_t = {1'b0, alu_a}                  + {4'd0, w_c};
         endcase
         alu_y       = w_t[3:0];
         alu_cout_re = ~w_t[4];
      end
   end

   // Whole-word reference computed directly from the operation definitions.
   function automatic void ref_op(input logic [W-1:0] a, b, input logic [3:0] s,
                                  input logic m, cin, output logic [W-1:0] r,
                                  output logic c, z, v);
      logic [W:0]   t;
      logic [W-1:0] x;
      c = 1'b0;
      if (m) begin
         case (s)
            4'h0:    r = ~a;
            4'h6:    r = a ^ b;
            4'h9:    r = ~(a ^ b);
            4'hB:    r = a & b;
            4'hE:    r = a | b;
            default: r = a;
         endcase
      end else begin
         case (s)
            4'h9:    x = b;
            4'h6:    x = ~b;
            4'hF:    x = '1;
            default: x = '0;
         endcase
         t = {1'b0, a} + {1'b0, x} + (W+1)'(cin);
         r = t[W-1:0];
         c = t[W];
      end
      z = (r == '0);
      if (!m && s == 4'h9)      v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      else if (!m && s == 4'h6) v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      else                      v = 1'b0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one operation and observe NIB+4 cycles; done latency counted in edges after the start edge.
   task automatic do_op(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cin);
      @(negedge clk);
      op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op_a = W'($urandom); op_b = W'($urandom); op_s = 4'($urandom);
      op_m = 1'($urandom); op_cin = 1'($urandom);
      lat = -1; npulse = 0; cin_ok = 1'b1;
      for (int i = 1; i <= NIB + 4; i++) begin
         if (busy && !done && m && alu_cin_re !== 1'b1) cin_ok = 1'b0;
         if (done === 1'b1) begin
            npulse++;
            if (lat < 0) lat = i;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_op(input string nm, input logic [W-1:0] er, input logic ec, ez, eo, input logic m);
      chk({nm, "_result"}, 32'(result), 32'(er));
      chk({nm, "_cout"}, 32'(cout), 32'(ec));
      chk({nm, "_zero"}, 32'(zero), 32'(ez));
      chk({nm, "_latency"}, 32'(lat), 32'(NIB + 1));
      chk({nm, "_done_pulses"}, 32'(npulse), 32'd1);
      if (m) chk({nm, "_cin_re_high"}, 32'(cin_ok), 32'd1);
`ifdef ALU_NIBBLE_SEQ_OVF_EN
      chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) n_errors++;
`endif
   endtask

   typedef struct {
      logic [W-1:0] a, b;
      logic [3:0]   s;
      logic         m, cin;
      logic [W-1:0] er;
      logic         ec, ez, eo;
   } vec_t;

   vec_t tbl[9];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] r, hold;
      logic c, z, v;
      logic [3:0] sel [6];
      int cnt;

      tbl[0] = '{16'h1234, 16'h0FFF, 4'h9, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{16'h5000, 16'h1234, 4'h6, 1'b0, 1'b1, 16'h3DCC, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{16'h0001, 16'h0002, 4'h6, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{16'h00FF, 16'h0000, 4'h9, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{16'hAAAA, 16'h5555, 4'h9, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{16'h7FFF, 16'h0001, 4'h9, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{16'h0001, 16'h0001, 4'h9, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
      sel = '{4'h0, 4'h6, 4'h9, 4'hB, 4'hE, 4'hF};

      rst = 1'b1; start = 1'b0;
      op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      rst = 1'b0;
      op_a = 16'hABCD; op_b = 16'h1357; op_s = 4'h9; op_m = 1'b1;
      @(negedge clk);
      chk("idle_alu_a", 32'(alu_a), 32'd0);
      chk("idle_alu_b", 32'(alu_b), 32'd0);
      chk("idle_alu_s", 32'(alu_s), 32'd0);
      chk("idle_alu_m", 32'(alu_m), 32'd0);
      chk("idle_alu_cin_re", 32'(alu_cin_re), 32'd1);

      for (int i = 0; i < 9; i++) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m, tbl[i].cin);
         check_op($sformatf("vec%0d", i), tbl[i].er, tbl[i].ec, tbl[i].ez, tbl[i].eo, tbl[i].m);
      end

      // Results hold in IDLE while inputs move.
      hold = result;
      repeat (3) @(negedge clk);
      chk("hold_result", 32'(result), 32'(hold));
      chk("hold_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] a, b;
         logic [3:0] s;
         logic m, cin;
         a = W'($urandom); b = W'($urandom);
         s = sel[$urandom_range(0, 5)];
         m = 1'($urandom); cin = 1'($urandom);
         if (i % 7 == 0) b = ~a;
         ref_op(a, b, s, m, cin, r, c, z, v);
         do_op(a, b, s, m, cin);
         check_op($sformatf("rand%0d", i), r, c, z, v, m);
      end

      // Second start while running is dropped.
      @(negedge clk);
      op_a = 16'h1234; op_b = 16'h0FFF; op_s = 4'h9; op_m = 1'b0; op_cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      op_a = 16'hFFFF; op_b = 16'h0001; start = 1'b1;
      @(negedge clk); start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (done === 1'b1) cnt++;
         @(negedge clk);
      end
      chk("busy_start_pulses", 32'(cnt), 32'd1);
      chk("busy_start_result", 32'(result), 32'h2233);
      chk("busy_start_idle", 32'(busy), 32'd0);

      // Start presented during the DONE cycle is dropped.
      @(negedge clk);
      op_a = 16'h0F0F; op_b = 16'h0101; op_s = 4'h9; op_m = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      cnt = 0;
      while (done !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("done_seen", 32'(done), 32'd1);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("done_start_ignored", 32'(busy), 32'd0);
      chk("done_start_result", 32'(result), 32'h1010);
      @(negedge clk);
      chk("done_start_still_idle", 32'(busy), 32'd0);

      // Reset two edges into a run aborts it.
      @(negedge clk);
      op_a = 16'hFFFF; op_b = 16'h0001; op_s = 4'h9; op_m = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_zero", 32'(zero), 32'd0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (done === 1'b1 || busy === 1'b1) cnt++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(cnt), 32'd0);

      // Reset wins over start.
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst_over_start", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
